fetch_module: RTL

- Instruction-fetch stage: producer side of the fetch→decode interface consumed by decode_module.
- Holds the PC and issues requests to a synchronous instruction memory with one-cycle read latency.
- Buffers returned words in a small queue and presents {instr, pc, pc+4} to decode over a valid/ready handshake.
- Accepts branch/jump redirects from decode/execute and flushes wrong-path instructions.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 72 +++++++
 rtl/fetch_module.sv | 110 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared fetch/decode types: word widths, the NOP encoding and the fetch packet
// handed from fetch_module to decode_module.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
  } fetch_pkt_t;

  // Sequential successor of a word address; wraps naturally modulo 2^32.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetch packets between the instruction memory response and
// decode. Flush empties it in one cycle; the head is read straight from storage.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_pkt_t       push_pkt,
  input  logic             pop,
  input  logic             flush,
  output fetch_pkt_t       head_pkt,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [DEPTH-1:0] wr_en;
  fetch_pkt_t       mem_reg [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && !flush && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '{instr: NOP, pc: '0, pc_plus4: '0};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) mem_reg[i] <= push_pkt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_pkt = mem_reg[rd_ptr_reg];
  assign count    = count_reg;

endmodule

// File: rtl/fetch_module.sv
// Instruction-fetch stage: PC, one-cycle imem requests, epoch-tagged redirects.
// Define FETCH_STATS_EN to add the stat_fetched / stat_stall counters.
module fetch_module
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_stall
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_reg;
  logic              epoch_reg;
  logic              inflight_reg;
  logic              inflight_epoch_reg;
  logic [ADDR_W-1:0] inflight_addr_reg;

  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic [CNT_W:0]    limit;
  logic              push;
  logic              pop;
  fetch_pkt_t        push_pkt;
  fetch_pkt_t        head_pkt;
  logic              unused_redirect_lsbs;

  assign if_valid = (count != '0);
  assign pop      = if_valid && if_ready;

  // A head leaving this cycle frees a slot, which is what sustains one fetch per cycle.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_reg};
  assign limit     = (CNT_W + 1)'(DEPTH) + {{CNT_W{1'b0}}, pop};
  assign imem_req  = rst_n && !redirect_valid && (occupancy < limit);
  assign imem_addr = pc_reg;

  // Responses tagged with an older epoch belong to the wrong path.
  assign push     = inflight_reg && (inflight_epoch_reg == epoch_reg);
  assign push_pkt = '{instr: imem_rdata, pc: inflight_addr_reg,
                      pc_plus4: next_pc(inflight_addr_reg)};

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg             <= RESET_PC;
      epoch_reg          <= 1'b0;
      inflight_reg       <= 1'b0;
      inflight_epoch_reg <= 1'b0;
      inflight_addr_reg  <= '0;
    end else if (redirect_valid) begin
      pc_reg       <= {redirect_pc[31:2], 2'b00};
      epoch_reg    <= ~epoch_reg;
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= imem_req;
      if (imem_req) begin
        pc_reg             <= next_pc(pc_reg);
        inflight_epoch_reg <= epoch_reg;
        inflight_addr_reg  <= pc_reg;
      end
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_pkt (push_pkt),
    .pop      (pop),
    .flush    (redirect_valid),
    .head_pkt (head_pkt),
    .count    (count)
  );

  assign if_instr    = head_pkt.instr;
  assign if_pc       = head_pkt.pc;
  assign if_pc_plus4 = head_pkt.pc_plus4;

`ifdef FETCH_STATS_EN
  // Saturating counters that survive redirects; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched <= '0;
      stat_stall   <= '0;
    end else begin
      if (pop && (stat_fetched != '1)) stat_fetched <= stat_fetched + 1'b1;
      if (if_valid && !if_ready && (stat_stall != '1)) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule
